// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: glyph ROM, blank pattern and
// the pin-polarity helper used at the output register.
package seg7_pkg;

  // Logical (active-high) a..g patterns on bits 6..0, indexed by nibble value.
  localparam logic [15:0][6:0] GLYPH = {
    7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };

  localparam logic [6:0] SEG_OFF = 7'h00;

  typedef enum logic {
    PH_DEAD,
    PH_SHOW
  } phase_e;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
  } seg_pins_t;

  function automatic logic [6:0] apply_pol(input logic [6:0] value, input logic active_low);
    return active_low ? ~value : value;
  endfunction

endpackage

// File: rtl/hex7_glyph.sv
// Combinational hex-nibble to logical 7-segment pattern decoder.
module hex7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] glyph
);

  assign glyph = GLYPH[nib];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver: shadow register, slot prescaler, digit
// index, leading-zero blanking and a registered, polarity-corrected pin stage.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int DEAD           = 2,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic                  en,
  output logic [6:0]            seg,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     an
);

  localparam int PCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic        SEG_AL   = (SEG_ACTIVE_LOW != 0);
  localparam logic        AN_AL    = (AN_ACTIVE_LOW != 0);
  localparam logic [31:0] LAST_PC  = 32'(SCAN_DIV - 1);
  localparam logic [31:0] LAST_IDX = 32'(DIGITS - 1);
  localparam logic [31:0] DEAD_W   = 32'(DEAD);

  logic [PCW-1:0]             pcnt_q, pcnt_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic [DIGITS-1:0][3:0]     data_q, data_d;
  logic [DIGITS-1:0]          dp_q, dp_d;
  logic [DIGITS-1:0][3:0]     data_w;
  logic [DIGITS-1:0][6:0]     glyph_w;
  logic [DIGITS-1:0]          blank_w;
  logic                       zero_above;
  logic                       slot_end;
  phase_e                     phase;

  seg_pins_t                  lane_sel;
  seg_pins_t                  pins_q, pins_d;
  logic [DIGITS-1:0]          an_sel;
  logic [DIGITS-1:0]          an_q, an_d;

  assign data_w = data;

  // One decoder per digit; the scan mux picks the active lane.
  for (genvar k = 0; k < DIGITS; k++) begin : g_lane
    hex7_glyph u_glyph (
      .nib   (data_q[k]),
      .glyph (glyph_w[k])
    );
  end

  // Full-width compares so a power-of-two SCAN_DIV never aliases.
  assign slot_end = (32'(pcnt_q) == LAST_PC);
  assign phase    = (32'(pcnt_q) < DEAD_W) ? PH_DEAD : PH_SHOW;

  always_comb begin
    pcnt_d = pcnt_q;
    idx_d  = idx_q;
    if (en) begin
      if (slot_end) begin
        pcnt_d = '0;
        idx_d  = (32'(idx_q) == LAST_IDX) ? '0 : idx_q + IW'(1);
      end else begin
        pcnt_d = pcnt_q + PCW'(1);
      end
    end
  end

  always_comb begin
    data_d = data_q;
    dp_d   = dp_q;
    if (load) begin
      data_d = data_w;
      dp_d   = dp;
    end
  end

  // A digit is blank when it and every digit above it hold zero; digit 0 never is.
  always_comb begin
    zero_above = 1'b1;
    blank_w    = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above & (data_q[k] == 4'h0);
      blank_w[k] = blank_lz & zero_above;
    end
  end

  always_comb begin
    an_sel       = '0;
    lane_sel.seg = SEG_OFF;
    lane_sel.dp  = 1'b0;
    if (en && phase == PH_SHOW) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (idx_q == IW'(k)) begin
          an_sel[k]    = 1'b1;
          lane_sel.dp  = dp_q[k];
          lane_sel.seg = blank_w[k] ? SEG_OFF : glyph_w[k];
        end
      end
    end
    pins_d.seg = apply_pol(lane_sel.seg, SEG_AL);
    pins_d.dp  = lane_sel.dp ^ SEG_AL;
    an_d       = an_sel ^ {DIGITS{AN_AL}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q     <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      dp_q       <= '0;
      pins_q.seg <= apply_pol(SEG_OFF, SEG_AL);
      pins_q.dp  <= SEG_AL;
      an_q       <= {DIGITS{AN_AL}};
    end else begin
      pcnt_q <= pcnt_d;
      idx_q  <= idx_d;
      data_q <= data_d;
      dp_q   <= dp_d;
      pins_q <= pins_d;
      an_q   <= an_d;
    end
  end

  assign seg    = pins_q.seg;
  assign dp_out = pins_q.dp;
  assign an     = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: three parameterisations checked every cycle
// against a tick-count reference model, plus directed scenario checks.
module tb_seg7_scan_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, load, blz;
  logic [15:0] data;
  logic [3:0]  dp;
  logic [3:0]  a_an, b_an;
  logic [6:0]  a_seg, b_seg;
  logic        a_dp, b_dp;

  logic        c_load, c_blz, c_dp_in, c_an, c_dpo;
  logic [3:0]  c_data;
  logic [6:0]  c_seg;

  seg7_scan_driver #(.DIGITS(4), .SCAN_DIV(8), .DEAD(2), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)) u_dut_a (
    .clk(clk), .rst(rst), .data(data), .dp(dp), .load(load), .blank_lz(blz), .en(en),
    .seg(a_seg), .dp_out(a_dp), .an(a_an));

  seg7_scan_driver #(.DIGITS(4), .SCAN_DIV(8), .DEAD(2), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(0)) u_dut_b (
    .clk(clk), .rst(rst), .data(data), .dp(dp), .load(load), .blank_lz(blz), .en(en),
    .seg(b_seg), .dp_out(b_dp), .an(b_an));

  seg7_scan_driver #(.DIGITS(1), .SCAN_DIV(2), .DEAD(0), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)) u_dut_c (
    .clk(clk), .rst(rst), .data(c_data), .dp(c_dp_in), .load(c_load), .blank_lz(c_blz), .en(en),
    .seg(c_seg), .dp_out(c_dpo), .an(c_an));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  logic [6:0] gl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                          7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // Expected pins {an[3:0], seg[6:0], dp} for a given enabled-tick count and shadow.
  function automatic logic [11:0] model(input int dg, input int sd, input int dead,
                                        input int sal, input int aal, input int tk,
                                        input logic [15:0] sh, input logic [3:0] dps,
                                        input logic en_i, input logic blz_i, input logic rst_i);
    logic [3:0]  a;
    logic [6:0]  s;
    logic        d;
    logic [15:0] up;
    int          pc, ix;
    a = '0; s = '0; d = 1'b0;
    pc = tk % sd;
    ix = (tk / sd) % dg;
    if (!rst_i && en_i && pc >= dead) begin
      a[ix] = 1'b1;
      d     = dps[ix];
      up    = sh >> (4 * ix);
      if (!(blz_i && ix != 0 && up == 16'h0)) s = gl[up[3:0]];
    end
    if (aal != 0) a = a ^ 4'((1 << dg) - 1);
    if (sal != 0) begin s = ~s; d = ~d; end
    return {a, s, d};
  endfunction

  int          tk4 = 0, tkc = 0;
  logic [15:0] sh4 = '0;
  logic [3:0]  dp4 = '0;
  logic [3:0]  shc = '0;
  logic        dpc = 1'b0;
  logic [11:0] ea, eb, ec;
  logic        arm = 1'b0;

  always @(posedge clk) begin
    ea <= model(4, 8, 2, 0, 1, tk4, sh4, dp4, en, blz, rst);
    eb <= model(4, 8, 2, 1, 0, tk4, sh4, dp4, en, blz, rst);
    ec <= model(1, 2, 0, 0, 1, tkc, {12'h0, shc}, {3'b0, dpc}, en, c_blz, rst);
    if (rst) begin
      tk4 <= 0; sh4 <= '0; dp4 <= '0;
      tkc <= 0; shc <= '0; dpc <= 1'b0;
    end else begin
      if (load) begin sh4 <= data; dp4 <= dp; end
      if (c_load) begin shc <= c_data; dpc <= c_dp_in; end
      if (en) begin tk4 <= tk4 + 1; tkc <= tkc + 1; end
    end
  end

  always @(negedge clk) begin
    if (arm) begin
      chk("a_an",  32'(a_an),  32'(ea[11:8]));
      chk("a_seg", 32'(a_seg), 32'(ea[7:1]));
      chk("a_dp",  32'(a_dp),  32'(ea[0]));
      chk("b_an",  32'(b_an),  32'(eb[11:8]));
      chk("b_seg", 32'(b_seg), 32'(eb[7:1]));
      chk("b_dp",  32'(b_dp),  32'(eb[0]));
      chk("c_an",  32'(c_an),  32'(ec[8]));
      chk("c_seg", 32'(c_seg), 32'(ec[7:1]));
      chk("c_dp",  32'(c_dpo), 32'(ec[0]));
    end
  end

  task automatic wait_phase(input int pc, input int ix, input string tag);
    int g = 0;
    while (!((tk4 % 8) == pc && ((tk4 / 8) % 4) == ix) && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk(tag, 32'(g >= 200), 32'(0));
  endtask

  int          on_cnt [4];
  logic [15:0] rd;

  initial begin
    rst = 1'b1; en = 1'b1; load = 1'b0; blz = 1'b0; data = '0; dp = '0;
    c_load = 1'b0; c_blz = 1'b0; c_dp_in = 1'b0; c_data = '0;
    repeat (2) @(negedge clk);
    arm = 1'b1;
    chk("rst_a_an", 32'(a_an), 32'h0F);
    chk("rst_a_seg", 32'(a_seg), 32'h00);
    chk("rst_a_dp", 32'(a_dp), 32'h0);
    chk("rst_b_an", 32'(b_an), 32'h0);
    chk("rst_b_seg", 32'(b_seg), 32'h7F);
    chk("rst_b_dp", 32'(b_dp), 32'h1);
    chk("rst_c_an", 32'(c_an), 32'h1);

    // Basic scan of 1234: release reset and load on the same edge.
    rst = 1'b0; load = 1'b1; data = 16'h1234;
    @(negedge clk);
    load = 1'b0;
    for (int k = 0; k < 4; k++) on_cnt[k] = 0;
    for (int e = 1; e < 32; e++) begin
      @(negedge clk);
      case (e)
        2:  begin chk("scan0_an", 32'(a_an), 32'b1110); chk("scan0_seg", 32'(a_seg), 32'h33); end
        8:  begin chk("dead_an", 32'(a_an), 32'hF);     chk("dead_seg", 32'(a_seg), 32'h00); end
        10: begin chk("scan1_an", 32'(a_an), 32'b1101); chk("scan1_seg", 32'(a_seg), 32'h79); end
        18: begin chk("scan2_an", 32'(a_an), 32'b1011); chk("scan2_seg", 32'(a_seg), 32'h6D); end
        26: begin chk("scan3_an", 32'(a_an), 32'b0111); chk("scan3_seg", 32'(a_seg), 32'h30); end
        default: ;
      endcase
      for (int k = 0; k < 4; k++) if (!a_an[k]) on_cnt[k]++;
    end
    for (int k = 0; k < 4; k++) chk($sformatf("on_time_d%0d", k), 32'(on_cnt[k]), 32'd6);

    // Freeze at pcnt=5, idx=2 and resume from there.
    wait_phase(5, 2, "wait_en");
    en = 1'b0;
    repeat (4) @(negedge clk);
    chk("off_a_an", 32'(a_an), 32'hF);
    chk("off_a_seg", 32'(a_seg), 32'h00);
    chk("off_b_an", 32'(b_an), 32'h0);
    chk("off_b_seg", 32'(b_seg), 32'h7F);
    chk("off_b_dp", 32'(b_dp), 32'h1);
    en = 1'b1;
    @(negedge clk);
    chk("resume_an", 32'(a_an), 32'b1011);
    chk("resume_seg", 32'(a_seg), 32'h6D);

    // Mid-slot reset.
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_a_an", 32'(a_an), 32'hF);
    chk("mrst_a_seg", 32'(a_seg), 32'h00);
    chk("mrst_b_an", 32'(b_an), 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("restart_an", 32'(a_an), 32'b1110);
    chk("restart_seg", 32'(a_seg), 32'h7E);

    // Load timing on digit 0 while it is in SHOW.
    wait_phase(3, 0, "wait_ld");
    load = 1'b1; data = 16'h000F;
    @(negedge clk);
    load = 1'b0;
    chk("ld_t_seg", 32'(a_seg), 32'h7E);
    @(negedge clk);
    chk("ld_t1_seg", 32'(a_seg), 32'h47);
    data = 16'h0005;
    repeat (2) @(negedge clk);
    chk("noload_seg", 32'(a_seg), 32'h47);

    // Leading-zero blanking.
    blz = 1'b1; load = 1'b1; data = 16'h0070;
    @(negedge clk);
    load = 1'b0;
    wait_phase(4, 3, "wait_lz3");
    @(negedge clk);
    chk("lz_d3_an", 32'(a_an), 32'b0111);
    chk("lz_d3_seg", 32'(a_seg), 32'h00);
    wait_phase(4, 1, "wait_lz1");
    @(negedge clk);
    chk("lz_d1_seg", 32'(a_seg), 32'h70);
    load = 1'b1; data = 16'h0000;
    @(negedge clk);
    load = 1'b0;
    wait_phase(4, 1, "wait_lz1z");
    @(negedge clk);
    chk("lz0_d1_an", 32'(a_an), 32'b1101);
    chk("lz0_d1_seg", 32'(a_seg), 32'h00);
    wait_phase(4, 0, "wait_lz0z");
    @(negedge clk);
    chk("lz0_d0_seg", 32'(a_seg), 32'h7E);

    // Randomised traffic, checked every cycle by the model.
    repeat (2000) begin
      @(negedge clk);
      rst  = ($urandom % 256) == 0;
      load = ($urandom % 6) == 0;
      en   = ($urandom % 16) != 0;
      if (($urandom % 32) == 0) blz = ~blz;
      for (int k = 0; k < 4; k++) rd[4*k +: 4] = ($urandom % 2) ? 4'($urandom % 16) : 4'h0;
      data    = rd;
      dp      = 4'($urandom);
      c_load  = ($urandom % 4) == 0;
      c_data  = 4'($urandom);
      c_dp_in = 1'($urandom);
      c_blz   = 1'($urandom);
    end

    // Single-digit instance: every nibble value.
    @(negedge clk);
    rst = 1'b0; en = 1'b1; load = 1'b0; c_load = 1'b0;
    @(negedge clk);
    for (int n = 0; n < 16; n++) begin
      c_data = 4'(n); c_load = 1'b1;
      @(negedge clk);
      c_load = 1'b0;
      @(negedge clk);
      chk($sformatf("c_sweep_seg_%0d", n), 32'(c_seg), 32'(gl[n]));
      chk($sformatf("c_sweep_an_%0d", n), 32'(c_an), 32'h0);
    end

    arm = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
